shift_serializer_sched: RTL and testbench



---
 rtl/shift_serializer_sched_pkg.sv | 17 +
 rtl/shift_serializer_sched_arb.sv | 48 ++++
 rtl/shift_serializer_sched.sv | 118 +++++++++++
 tb/tb_shift_serializer_sched.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_serializer_sched_pkg.sv
// Shared definitions for the shift_serializer_sched block.
// Contents:
//   state_t     - controller states (IDLE / SHIFT / GAP)
//   GRANT_REQ0  - grant ID value for requester 0
//   GRANT_REQ1  - grant ID value for requester 1
package shift_serializer_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic GRANT_REQ0 = 1'b0;
  localparam logic GRANT_REQ1 = 1'b1;

endpackage

// File: rtl/shift_serializer_sched_arb.sv
// shift_rr_arb2: two-way round-robin arbiter with a combinational grant.
// Ports:
//   clock, reset     - clock and asynchronous active-high reset
//   enable           - arbitration window (serializer idle and out of reset)
//   valid0, valid1   - request lines
//   ready0, ready1   - combinational accept strobes (at most one high)
//   winner           - requester selected in this cycle
module shift_rr_arb2
  import shift_serializer_sched_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic valid0,
  input  logic valid1,
  output logic ready0,
  output logic ready1,
  output logic winner
);

  logic last_grant;
  logic any_valid;

  // On contention the requester that did not win last time goes next;
  // a lone requester wins regardless of history.
  always_comb begin
    any_valid = valid0 | valid1;
    if (valid0 && valid1) begin
      winner = ~last_grant;
    end else if (valid0) begin
      winner = GRANT_REQ0;
    end else begin
      winner = GRANT_REQ1;
    end
    ready0 = enable && any_valid && (winner == GRANT_REQ0);
    ready1 = enable && any_valid && (winner == GRANT_REQ1);
  end

  // Reset to requester 1 so requester 0 wins the first contended grant.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant <= GRANT_REQ1;
    end else if (ready0 || ready1) begin
      last_grant <= winner;
    end
  end

endmodule

// File: rtl/shift_serializer_sched.sv
// shift_serializer_sched: shares one LSB-first parallel-to-serial shift
// register between two word requesters, with round-robin arbitration and a
// programmable idle gap after each frame.
// Ports:
//   clock, reset            - clock and asynchronous active-high reset
//   req0_valid/data/ready   - requester 0 handshake (ready is combinational)
//   req1_valid/data/ready   - requester 1 handshake (ready is combinational)
//   shift_en                - bit strobe; one bit advances per high cycle
//   ser_out, ser_valid      - serial bit and its qualifier
//   busy                    - controller not idle
//   grant_id                - requester owning the current/last frame
//   frame_done              - one-cycle pulse after the last bit of a frame
module shift_serializer_sched
  import shift_serializer_sched_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             grant_id,
  output logic             frame_done
);

  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             arb_enable;
  logic             winner;
  logic             accept;

  // Readies are held low while reset is asserted, not just after it.
  assign arb_enable = (state == ST_IDLE) && !reset;
  assign accept     = req0_ready | req1_ready;

  shift_rr_arb2 u_arb (
    .clock  (clock),
    .reset  (reset),
    .enable (arb_enable),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .ready0 (req0_ready),
    .ready1 (req1_ready),
    .winner (winner)
  );

  // Zero-filled right shifts leave the register at 0 once a frame is fully
  // shifted out, so bit 0 is already 0 whenever the controller is not in
  // SHIFT and can drive ser_out directly.
  assign ser_out = shreg[0];
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      grant_id   <= GRANT_REQ0;
      ser_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            shreg     <= (winner == GRANT_REQ1) ? req1_data : req0_data;
            bit_cnt   <= '0;
            grant_id  <= winner;
            ser_valid <= 1'b1;
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (shift_en) begin
            shreg <= {1'b0, shreg[WIDTH-1:1]};
            if (bit_cnt == BIT_LAST) begin
              bit_cnt    <= '0;
              gap_cnt    <= '0;
              ser_valid  <= 1'b0;
              frame_done <= 1'b1;
              state      <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
        ST_GAP: begin
          // Free-running idle time, independent of the bit strobe.
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_serializer_sched.sv
// Directed testbench for shift_serializer_sched.
// dut  : WIDTH=4, GAP_CYCLES=1
// dut0 : WIDTH=4, GAP_CYCLES=0 (back-to-back frames)
module tb_shift_serializer_sched;

  logic       clock = 1'b0;
  logic       reset = 1'b1;

  logic       req0_valid = 1'b0;
  logic [3:0] req0_data  = '0;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [3:0] req1_data  = '0;
  logic       req1_ready;
  logic       shift_en   = 1'b0;
  logic       ser_out, ser_valid, busy, grant_id, frame_done;

  logic       z_req0_valid = 1'b0;
  logic [3:0] z_req0_data  = '0;
  logic       z_req0_ready;
  logic       z_req1_valid = 1'b0;
  logic [3:0] z_req1_data  = '0;
  logic       z_req1_ready;
  logic       z_shift_en   = 1'b0;
  logic       z_ser_out, z_ser_valid, z_busy, z_grant_id, z_frame_done;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  shift_serializer_sched #(.WIDTH(4), .GAP_CYCLES(1)) dut (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .shift_en   (shift_en),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .busy       (busy),
    .grant_id   (grant_id),
    .frame_done (frame_done)
  );

  shift_serializer_sched #(.WIDTH(4), .GAP_CYCLES(0)) dut0 (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (z_req0_valid),
    .req0_data  (z_req0_data),
    .req0_ready (z_req0_ready),
    .req1_valid (z_req1_valid),
    .req1_data  (z_req1_data),
    .req1_ready (z_req1_ready),
    .shift_en   (z_shift_en),
    .ser_out    (z_ser_out),
    .ser_valid  (z_ser_valid),
    .busy       (z_busy),
    .grant_id   (z_grant_id),
    .frame_done (z_frame_done)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge (input drive point).
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] w;
    logic [7:0] e1;
    logic [7:0] e3;

    // ---------------- reset state ----------------
    req0_valid = 1'b1;
    req0_data  = 4'b1011;
    next_cycle();
    next_cycle();
    #1;
    chk("rst_req0_ready", req0_ready, 1'b0);
    chk("rst_req1_ready", req1_ready, 1'b0);
    chk("rst_ser_out", ser_out, 1'b0);
    chk("rst_ser_valid", ser_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant_id", grant_id, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);

    // ---------------- test 1: single frame 1011, shift_en high ----------
    next_cycle();
    reset    = 1'b0;
    shift_en = 1'b1;
    #1;
    chk("t1_req0_ready_c0", req0_ready, 1'b1);
    chk("t1_req1_ready_c0", req1_ready, 1'b0);
    chk("t1_busy_c0", busy, 1'b0);
    e1 = 8'b0000_1011;            // ser_out expected for cycles 1..4 at bits 0..3
    for (int c = 1; c <= 6; c++) begin
      next_cycle();
      req0_valid = 1'b0;
      #1;
      chk("t1_busy", busy, (c <= 5));
      chk("t1_ser_valid", ser_valid, (c <= 4));
      chk("t1_frame_done", frame_done, (c == 5));
      if (c <= 4) begin
        chk("t1_ser_out", ser_out, e1[c-1]);
        chk("t1_grant_id", grant_id, 1'b0);
      end
    end

    // ---------------- test 2: both valid, alternating grants ------------
    reset_pulse();
    req0_valid = 1'b1;
    req0_data  = 4'hA;
    req1_valid = 1'b1;
    req1_data  = 4'h5;
    shift_en   = 1'b1;
    for (int c = 0; c < 24; c++) begin
      if (c > 0) next_cycle();
      #1;
      chk("t2_ready_exclusive", req0_ready & req1_ready, 1'b0);
      if (c % 6 == 0) begin
        chk("t2_req0_ready", req0_ready, ((c / 6) % 2) == 0);
        chk("t2_req1_ready", req1_ready, ((c / 6) % 2) == 1);
      end else begin
        chk("t2_no_ready", req0_ready | req1_ready, 1'b0);
      end
      if ((c % 6) >= 1 && (c % 6) <= 4) begin
        w = (((c / 6) % 2) == 0) ? 4'hA : 4'h5;
        chk("t2_grant_id", grant_id, ((c / 6) % 2) == 1);
        chk("t2_ser_out", ser_out, w[(c % 6) - 1]);
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // ---------------- test 3: strobe every other cycle, req1 0110 -------
    reset_pulse();
    req1_valid = 1'b1;
    req1_data  = 4'b0110;
    shift_en   = 1'b1;
    #1;
    chk("t3_req1_ready_c0", req1_ready, 1'b1);
    chk("t3_req0_ready_c0", req0_ready, 1'b0);
    e3 = 8'b0011_1100;
    for (int c = 1; c <= 8; c++) begin
      next_cycle();
      req1_valid = 1'b0;
      shift_en   = (c % 2 == 0);
      #1;
      chk("t3_ser_out", ser_out, e3[c-1]);
      chk("t3_ser_valid", ser_valid, 1'b1);
      chk("t3_frame_done", frame_done, 1'b0);
    end

    // ---------------- test 6: req1 valid during GAP ---------------------
    next_cycle();                 // cycle 9: GAP
    shift_en   = 1'b0;
    req1_valid = 1'b1;
    req1_data  = 4'h9;
    #1;
    chk("t3_frame_done_c9", frame_done, 1'b1);
    chk("t6_busy_gap", busy, 1'b1);
    chk("t6_ser_valid_gap", ser_valid, 1'b0);
    chk("t6_req1_ready_gap", req1_ready, 1'b0);
    next_cycle();                 // cycle 10: IDLE
    #1;
    chk("t6_busy_idle", busy, 1'b0);
    chk("t6_req1_ready_idle", req1_ready, 1'b1);
    next_cycle();                 // cycle 11: SHIFT, valid still high
    #1;
    chk("t6_req1_ready_after", req1_ready, 1'b0);
    chk("t6_grant_id", grant_id, 1'b1);
    chk("t6_ser_out", ser_out, 1'b1);
    req1_valid = 1'b0;

    // ---------------- test 4: GAP_CYCLES=0 back-to-back -----------------
    reset_pulse();
    z_req0_valid = 1'b1;
    z_req0_data  = 4'hF;
    z_shift_en   = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (c > 0) next_cycle();
      #1;
      chk("t4_ready", z_req0_ready, (c % 5 == 0));
      chk("t4_ser_valid", z_ser_valid, (c % 5 != 0));
      chk("t4_ser_out", z_ser_out, (c % 5 != 0));
      chk("t4_frame_done", z_frame_done, (c > 0) && (c % 5 == 0));
    end
    z_req0_valid = 1'b0;

    // ---------------- test 5: async reset mid-SHIFT ---------------------
    reset_pulse();
    req0_valid = 1'b1;
    req0_data  = 4'hA;
    req1_valid = 1'b1;
    req1_data  = 4'h5;
    shift_en   = 1'b1;
    #1;
    chk("t5_req0_ready_c0", req0_ready, 1'b1);
    next_cycle();
    #1;
    chk("t5_ser_out_c1", ser_out, 1'b0);
    chk("t5_ser_valid_c1", ser_valid, 1'b1);
    next_cycle();
    #1;
    chk("t5_ser_out_c2", ser_out, 1'b1);
    reset = 1'b1;
    #1;
    chk("t5_abort_ser_out", ser_out, 1'b0);
    chk("t5_abort_ser_valid", ser_valid, 1'b0);
    chk("t5_abort_busy", busy, 1'b0);
    chk("t5_abort_frame_done", frame_done, 1'b0);
    chk("t5_abort_req0_ready", req0_ready, 1'b0);
    chk("t5_abort_req1_ready", req1_ready, 1'b0);
    next_cycle();
    chk("t5_hold_frame_done", frame_done, 1'b0);
    reset = 1'b0;
    #1;
    chk("t5_post_req0_ready", req0_ready, 1'b1);
    chk("t5_post_req1_ready", req1_ready, 1'b0);
    next_cycle();
    #1;
    chk("t5_post_frame_done", frame_done, 1'b0);
    chk("t5_post_grant_id", grant_id, 1'b0);
    chk("t5_post_ser_valid", ser_valid, 1'b1);
    chk("t5_post_ser_out", ser_out, 1'b0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
